wasm_run_monitor: RTL and testbench

Synthesizable run supervisor for the WASM core: starts a program run, counts execution cycles until the core reports completion, and watches a parametrised set of error lines plus a cycle-budget watchdog. The end-of-run status, cycle count and first-error identity are latched into registered outputs. It sits beside WASM_TOP, drives the core's run enable, and consumes `o_instr_finish` and the core error flags (`o_INSTR_ERROR`, `o_stack_exceed`, `o_stack_empty_pop`, …).

---
 rtl/wasm_run_monitor.sv | 157 +++++++++++++++
 tb/tb_wasm_run_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_run_monitor.sv
// Run supervisor for the WASM core: run enable, cycle count,
// error capture and watchdog with latched end-of-run status.
module wasm_run_monitor #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 500,
  parameter int N_ERR       = 3,
  parameter bit STOP_ON_ERR = 1'b1,
  parameter int ERR_ID_W    = (N_ERR > 1) ? $clog2(N_ERR) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_clr,
  input  logic                i_finish,
  input  logic [N_ERR-1:0]    i_err,
  output logic                o_run,
  output logic                o_done,
  output logic                o_done_pulse,
  output logic [1:0]          o_status,
  output logic [CNT_W-1:0]    o_cycles,
  output logic [N_ERR-1:0]    o_err_vec,
  output logic [ERR_ID_W-1:0] o_err_id,
  output logic                o_err_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  localparam logic [CNT_W:0] TMO_V = (CNT_W+1)'(TIMEOUT);
  localparam logic [CNT_W:0] ONE_V = (CNT_W+1)'(1);

  state_t              r_state;
  logic                r_run;
  logic                r_done;
  logic                r_pulse;
  logic [1:0]          r_status;
  logic [CNT_W-1:0]    r_cycles;
  logic [N_ERR-1:0]    r_err_vec;
  logic [ERR_ID_W-1:0] r_err_id;
  logic                r_err_val;

  logic [CNT_W:0]      w_cyc_inc;
  logic [CNT_W-1:0]    w_cyc_nx;
  logic                w_err_any;
  logic                w_tmo_hit;
  logic [ERR_ID_W-1:0] w_first_id;
  logic                w_end;
  logic [1:0]          w_end_st;

  // extra top bit detects the all-ones wrap so the count saturates
  assign w_cyc_inc = {1'b0, r_cycles} + ONE_V;
  assign w_cyc_nx  = w_cyc_inc[CNT_W] ? r_cycles
                                      : w_cyc_inc[CNT_W-1:0];
  assign w_err_any = |i_err;
  assign w_tmo_hit = (TIMEOUT != 0) && (w_cyc_inc == TMO_V);

  always_comb begin
    w_first_id = '0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (i_err[i]) w_first_id = ERR_ID_W'(i);
    end
  end

  always_comb begin
    w_end    = 1'b0;
    w_end_st = ST_NONE;
    if (STOP_ON_ERR && w_err_any) begin
      w_end    = 1'b1;
      w_end_st = ST_ERR;
    end else if (i_finish) begin
      w_end    = 1'b1;
      w_end_st = ((r_err_vec | i_err) != '0) ? ST_ERR : ST_PASS;
    end else if (w_tmo_hit) begin
      w_end    = 1'b1;
      w_end_st = ST_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
      r_pulse   <= 1'b0;
      r_status  <= ST_NONE;
      r_cycles  <= '0;
      r_err_vec <= '0;
      r_err_id  <= '0;
      r_err_val <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_clr) begin
        r_state   <= S_IDLE;
        r_run     <= 1'b0;
        r_done    <= 1'b0;
        r_status  <= ST_NONE;
        r_cycles  <= '0;
        r_err_vec <= '0;
        r_err_id  <= '0;
        r_err_val <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              r_state   <= S_RUN;
              r_run     <= 1'b1;
              r_done    <= 1'b0;
              r_status  <= ST_NONE;
              r_cycles  <= '0;
              r_err_vec <= '0;
              r_err_id  <= '0;
              r_err_val <= 1'b0;
            end
          end
          S_RUN: begin
            r_cycles  <= w_cyc_nx;
            r_err_vec <= r_err_vec | i_err;
            if (w_err_any && !r_err_val) begin
              r_err_val <= 1'b1;
              r_err_id  <= w_first_id;
            end
            if (w_end) begin
              r_state  <= S_DONE;
              r_run    <= 1'b0;
              r_done   <= 1'b1;
              r_pulse  <= 1'b1;
              r_status <= w_end_st;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_run        = r_run;
  assign o_done       = r_done;
  assign o_done_pulse = r_pulse;
  assign o_status     = r_status;
  assign o_cycles     = r_cycles;
  assign o_err_vec    = r_err_vec;
  assign o_err_id     = r_err_id;
  assign o_err_valid  = r_err_val;

endmodule

// File: tb/tb_wasm_run_monitor.sv
// Bench for wasm_run_monitor: two configurations share stimulus,
// each tracked by a run-level reference model.
module tb_wasm_run_monitor;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_clr;
  logic       i_finish;
  logic [2:0] i_err;

  logic        a_run, a_done, a_pulse, a_val;
  logic [1:0]  a_status, a_id;
  logic [31:0] a_cycles;
  logic [2:0]  a_vec;

  logic        b_run, b_done, b_pulse, b_val;
  logic [1:0]  b_status, b_id;
  logic [3:0]  b_cycles;
  logic [2:0]  b_vec;

  wasm_run_monitor #(
    .CNT_W(32), .TIMEOUT(20), .N_ERR(3), .STOP_ON_ERR(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_clr(i_clr),
    .i_finish(i_finish), .i_err(i_err),
    .o_run(a_run), .o_done(a_done), .o_done_pulse(a_pulse),
    .o_status(a_status), .o_cycles(a_cycles), .o_err_vec(a_vec),
    .o_err_id(a_id), .o_err_valid(a_val)
  );

  wasm_run_monitor #(
    .CNT_W(4), .TIMEOUT(0), .N_ERR(3), .STOP_ON_ERR(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_clr(i_clr),
    .i_finish(i_finish), .i_err(i_err),
    .o_run(b_run), .o_done(b_done), .o_done_pulse(b_pulse),
    .o_status(b_status), .o_cycles(b_cycles), .o_err_vec(b_vec),
    .o_err_id(b_id), .o_err_valid(b_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // model: phase 0 idle, 1 running, 2 finished
  int     c_stop[2] = '{1, 0};
  int     c_tmo[2]  = '{20, 0};
  longint c_max[2]  = '{64'hFFFF_FFFF, 15};

  int     m_ph[2];
  longint m_cyc[2];
  int     m_ev[2], m_id[2], m_val[2], m_stat[2], m_pls[2];

  task automatic m_clear(int k);
    m_ph[k] = 0; m_cyc[k] = 0; m_ev[k] = 0; m_id[k] = 0;
    m_val[k] = 0; m_stat[k] = 0; m_pls[k] = 0;
  endtask

  task automatic m_step(int k, bit s, bit c, bit f, int e);
    longint old;
    m_pls[k] = 0;
    if (c) begin
      m_clear(k);
    end else if (m_ph[k] != 1) begin
      if (s) begin
        m_clear(k);
        m_ph[k] = 1;
      end
    end else begin
      old = m_cyc[k];
      m_cyc[k] = (old + 1 > c_max[k]) ? c_max[k] : old + 1;
      if (e != 0 && m_val[k] == 0) begin
        m_val[k] = 1;
        for (int i = 2; i >= 0; i--) if (e[i]) m_id[k] = i;
      end
      m_ev[k] = m_ev[k] | e;
      if (c_stop[k] != 0 && e != 0) begin
        m_ph[k] = 2; m_stat[k] = 2;
      end else if (f) begin
        m_ph[k] = 2; m_stat[k] = (m_ev[k] != 0) ? 2 : 1;
      end else if (c_tmo[k] != 0 && old + 1 == c_tmo[k]) begin
        m_ph[k] = 2; m_stat[k] = 3;
      end
      if (m_ph[k] == 2) m_pls[k] = 1;
    end
  endtask

  task automatic cmp(int k, logic run, logic done, logic pls,
                     logic [1:0] st, logic [31:0] cy, logic [2:0] ev,
                     logic [1:0] id, logic val);
    string p;
    p = (k == 0) ? "A." : "B.";
    chk({p, "run"}, run, (m_ph[k] == 1));
    chk({p, "done"}, done, (m_ph[k] == 2));
    chk({p, "pulse"}, pls, m_pls[k]);
    chk({p, "status"}, st, m_stat[k]);
    chk({p, "cycles"}, cy, m_cyc[k]);
    chk({p, "err_vec"}, ev, m_ev[k]);
    chk({p, "err_id"}, id, m_id[k]);
    chk({p, "err_valid"}, val, m_val[k]);
  endtask

  task automatic check_all();
    cmp(0, a_run, a_done, a_pulse, a_status, a_cycles, a_vec, a_id, a_val);
    cmp(1, b_run, b_done, b_pulse, b_status, {28'd0, b_cycles},
        b_vec, b_id, b_val);
  endtask

  task automatic cyc(bit s, bit c, bit f, logic [2:0] e);
    @(negedge clk);
    i_start = s; i_clr = c; i_finish = f; i_err = e;
    @(posedge clk);
    for (int k = 0; k < 2; k++) m_step(k, s, c, f, int'(e));
    #1;
    check_all();
  endtask

  task automatic async_rst();
    @(negedge clk);
    i_start = 0; i_clr = 0; i_finish = 0; i_err = 0;
    rst_n = 1'b0;
    #1;
    m_clear(0);
    m_clear(1);
    check_all();
    chk("rst.a_pulse", a_pulse, 0);
    chk("rst.a_cycles", a_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 0; i_clr = 0; i_finish = 0; i_err = 0;
    m_clear(0);
    m_clear(1);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // pass run
    cyc(1, 0, 0, 0);
    chk("pass.run", a_run, 1);
    repeat (9) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("pass.status", a_status, 1);
    chk("pass.cycles", a_cycles, 10);
    chk("pass.vec", a_vec, 0);
    chk("pass.pulse", a_pulse, 1);
    chk("pass.b_cycles", b_cycles, 10);
    cyc(0, 0, 0, 0);
    chk("pass.pulse_off", a_pulse, 0);
    chk("pass.held", a_done, 1);

    // stop on error
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 3'b110);
    chk("stop.done", a_done, 1);
    chk("stop.status", a_status, 2);
    chk("stop.cycles", a_cycles, 4);
    chk("stop.id", a_id, 1);
    chk("stop.vec", a_vec, 3'b110);
    chk("stop.b_run", b_run, 1);

    // continue on error
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 3'b100);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 3'b001);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("cont.status", b_status, 2);
    chk("cont.cycles", b_cycles, 8);
    chk("cont.id", b_id, 2);
    chk("cont.vec", b_vec, 3'b101);

    // watchdog, and saturation in the untimed config
    cyc(1, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 0);
    chk("tmo.status", a_status, 3);
    chk("tmo.cycles", a_cycles, 20);
    chk("sat.cycles", b_cycles, 15);
    chk("sat.run", b_run, 1);

    // error outranks finish on the timeout edge
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (19) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 3'b001);
    chk("prio.status", a_status, 2);
    chk("prio.cycles", a_cycles, 20);

    // abort and restart
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("abort.run", a_run, 0);
    chk("abort.done", a_done, 0);
    chk("abort.cycles", a_cycles, 0);
    cyc(1, 1, 0, 0);
    chk("clrstart.run", a_run, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 3'b010);
    cyc(1, 0, 0, 0);
    chk("restart.cycles", a_cycles, 0);
    chk("restart.status", a_status, 0);
    chk("restart.valid", a_val, 0);
    chk("restart.run", a_run, 1);

    // inputs ignored outside a run
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 3'b111);
    chk("ign.done_status", a_status, 1);
    chk("ign.done_vec", a_vec, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 3'b111);
    chk("ign.idle_vec", a_vec, 0);
    chk("ign.idle_done", a_done, 0);

    // async reset mid-run
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    async_rst();
    chk("arst.run", a_run, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit s, c, f;
      logic [2:0] e;
      s = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 39) == 0);
      f = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'd0;
      if ($urandom_range(0, 499) == 0) async_rst();
      else cyc(s, c, f, e);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
